// File: rtl/rv32imf_pkg.sv
// rv32imf_pkg: shared types for the instruction-side OBI responder.
package rv32imf_pkg;
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } obi_rsp_t;
endpackage

// File: rtl/rv32imf_obi_instr_responder_if.sv
// rv32imf_obi_instr_responder_if: OBI instruction fetch channel between fetch initiator and responder.
interface rv32imf_obi_instr_responder_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;
  modport master (output req, addr, input gnt, rvalid, rdata, err);
  modport slave (input req, addr, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/rv32imf_rsp_fifo.sv
// rv32imf_rsp_fifo: synchronous FIFO of OBI responses; head reads as zero when empty.
module rv32imf_rsp_fifo
  import rv32imf_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  obi_rsp_t      wdata,
  input  logic          pop,
  output obi_rsp_t      rdata,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);
  obi_rsp_t mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign rdata = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/rv32imf_obi_instr_responder.sv
// rv32imf_obi_instr_responder: answers OBI instruction fetches from an external synchronous RAM,
// flagging out-of-range addresses as bus errors and returning responses in grant order.
module rv32imf_obi_instr_responder
  import rv32imf_pkg::*;
#(
  parameter logic [31:0] MEM_BASE = 32'h0000_0000,
  parameter int MEM_WORDS = 16384,
  parameter int DEPTH = 2,
  localparam int RAM_AW = $clog2(MEM_WORDS),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  rv32imf_obi_instr_responder_if.slave bus,
  input  logic                       gnt_stall_i,
  input  logic                       rsp_stall_i,
  output logic                       ram_req_o,
  output logic [RAM_AW-1:0]          ram_addr_o,
  input  logic [31:0]                ram_rdata_i,
  output logic                       busy_o
);
  logic inflight_q, err_q, in_range, gnt, pop, empty, full;
  logic [CW-1:0] count;
  logic [31:0] occ;
  logic [32:0] off;
  obi_rsp_t head, wdata;
  // a borrow out of the 33-bit subtraction means the address lies below MEM_BASE
  assign off = {1'b0, bus.addr} - {1'b0, MEM_BASE};
  assign in_range = ~off[32] && off < (33'(MEM_WORDS) << 2);
  assign occ = 32'(count) + 32'(inflight_q);
  assign pop = bus.rvalid;
  assign gnt = rst_n & bus.req & ~gnt_stall_i & ((occ - 32'(pop)) < 32'(DEPTH)) & ~(full & ~pop);
  assign bus.gnt = gnt;
  assign ram_req_o = gnt & in_range;
  assign ram_addr_o = rst_n ? off[RAM_AW+1:2] : '0;
  assign wdata = err_q ? '{rdata: 32'h0, err: 1'b1} : '{rdata: ram_rdata_i, err: 1'b0};
  assign bus.rvalid = ~empty & ~rsp_stall_i;
  assign bus.rdata = head.rdata;
  assign bus.err = head.err;
  assign busy_o = occ != 0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      inflight_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      inflight_q <= gnt;
      err_q <= gnt & ~in_range;
    end
  rv32imf_rsp_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(inflight_q),
    .wdata(wdata),
    .pop(pop),
    .rdata(head),
    .empty(empty),
    .full(full),
    .count(count)
  );
endmodule

// File: tb/tb_rv32imf_obi_instr_responder.sv
// tb_rv32imf_obi_instr_responder: directed vectors plus randomized traffic against a queue-based
// model of outstanding fetches (each answer due two cycles after its grant, in grant order).
module tb_rv32imf_obi_instr_responder;
  localparam int DEPTH = 2;
  localparam int MEM_WORDS = 16384;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic gs = 1'b0;
  logic rs = 1'b0;
  logic ram_req;
  logic [13:0] ram_addr;
  logic [31:0] ram_rdata = 32'h0;
  logic busy;

  rv32imf_obi_instr_responder_if bus();

  rv32imf_obi_instr_responder #(.MEM_BASE(BASE), .MEM_WORDS(MEM_WORDS), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .gnt_stall_i(gs),
    .rsp_stall_i(rs),
    .ram_req_o(ram_req),
    .ram_addr_o(ram_addr),
    .ram_rdata_i(ram_rdata),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ram_word(input logic [31:0] idx);
    return (idx == 32'd32) ? 32'hDEAD_BEEF : (idx * 32'h0100_0193) ^ 32'hA5A5_5A5A;
  endfunction

  always @(posedge clk)
    if (ram_req) ram_rdata <= ram_word(32'(ram_addr));

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        gs, rs, gnt, rr, rv;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  exp_t q[$];
  vec_t tv[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int grants = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  task automatic cycle(input logic r, input logic [31:0] a, input logic g, input logic s);
    logic pop_e, gnt_e, inr;
    logic [31:0] off;
    @(posedge clk);
    #1;
    bus.req = r;
    bus.addr = a;
    gs = g;
    rs = s;
    @(negedge clk);
    cyc++;
    off = a - BASE;
    inr = (a >= BASE) && (off < 32'(MEM_WORDS * 4));
    pop_e = !s && q.size() > 0 && q[0].cyc + 2 <= cyc;
    gnt_e = r && !g && (q.size() - int'(pop_e) < DEPTH);
    chk("gnt", 32'(bus.gnt), 32'(gnt_e));
    chk("rvalid", 32'(bus.rvalid), 32'(pop_e));
    chk("ram_req", 32'(ram_req), 32'(gnt_e && inr));
    chk("busy", 32'(busy), 32'(q.size() != 0));
    if (gnt_e && inr) chk("ram_addr", 32'(ram_addr), (off >> 2) & 32'(MEM_WORDS - 1));
    if (pop_e) begin
      chk("rdata", bus.rdata, q[0].rdata);
      chk("err", 32'(bus.err), 32'(q[0].err));
      void'(q.pop_front());
    end else if (q.size() == 0) begin
      chk("idle_rdata", bus.rdata, 32'h0);
      chk("idle_err", 32'(bus.err), 32'h0);
    end
    if (bus.gnt) grants++;
    if (gnt_e) q.push_back('{inr ? ram_word(off >> 2) : 32'h0, !inr, cyc});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req = 1'b1;
    bus.addr = 32'h80;
    gs = 1'b0;
    rs = 1'b0;
    q.delete();
    @(negedge clk);
    @(negedge clk);
    chk("rst_gnt", 32'(bus.gnt), 32'h0);
    chk("rst_rvalid", 32'(bus.rvalid), 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_err", 32'(bus.err), 32'h0);
    chk("rst_ram_req", 32'(ram_req), 32'h0);
    chk("rst_ram_addr", 32'(ram_addr), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    bus.req = 1'b0;
    bus.addr = 32'h0;
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] a;
    logic r, g, s, hold;
    bus.req = 1'b0;
    bus.addr = 32'h0;
    tv = '{
      '{1'b1, 32'h80,    1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0},
      '{1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0},
      '{1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0},
      '{1'b1, 32'h83,    1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0},
      '{1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0},
      '{1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0},
      '{1'b1, 32'h10000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0},
      '{1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0},
      '{1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1},
      '{1'b1, 32'h0,     1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0},
      '{1'b1, 32'h4,     1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0},
      '{1'b1, 32'h8,     1'b0, 1'b0, 1'b1, 1'b1, 1'b1, ram_word(0), 1'b0},
      '{1'b1, 32'hC,     1'b0, 1'b0, 1'b1, 1'b1, 1'b1, ram_word(1), 1'b0},
      '{1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ram_word(2), 1'b0},
      '{1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ram_word(3), 1'b0},
      '{1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0},
      '{1'b1, 32'h84,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0},
      '{1'b1, 32'h84,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0},
      '{1'b1, 32'h84,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0},
      '{1'b1, 32'h84,    1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0},
      '{1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0},
      '{1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ram_word(33), 1'b0}
    };
    do_reset();
    foreach (tv[i]) begin
      cycle(tv[i].req, tv[i].addr, tv[i].gs, tv[i].rs);
      chk("tv_gnt", 32'(bus.gnt), 32'(tv[i].gnt));
      chk("tv_ram_req", 32'(ram_req), 32'(tv[i].rr));
      chk("tv_rvalid", 32'(bus.rvalid), 32'(tv[i].rv));
      chk("tv_rdata", bus.rdata, tv[i].rdata);
      chk("tv_err", 32'(bus.err), 32'(tv[i].err));
    end
    // response backpressure: only DEPTH fetches may be granted while answers are held
    grants = 0;
    a = 32'h100;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, a, 1'b0, 1'b1);
      if (bus.gnt) a += 4;
    end
    chk("bp_grants", 32'(grants), 32'd2);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, a, 1'b0, 1'b0);
      if (bus.gnt) a += 4;
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0);
    chk("bp_drained", 32'(q.size()), 32'h0);
    // reset with two answers queued: they must vanish
    cycle(1'b1, 32'h200, 1'b0, 1'b1);
    cycle(1'b1, 32'h204, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    chk("mid_busy_before", 32'(busy), 32'h1);
    do_reset();
    grants = 0;
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 32'h80, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    chk("mid_new_rdata", bus.rdata, 32'hDEAD_BEEF);
    chk("mid_grants", 32'(grants), 32'd1);
    // randomized traffic; an ungranted request keeps its address
    hold = 1'b0;
    r = 1'b0;
    a = 32'h0;
    for (int i = 0; i < 600; i++) begin
      if (!hold) begin
        r = $urandom_range(0, 9) < 7;
        a = ($urandom_range(0, 9) == 0) ? (32'h0001_0000 | $urandom)
                                        : ((32'($urandom_range(0, MEM_WORDS - 1)) << 2) | 32'($urandom_range(0, 3)));
      end
      g = $urandom_range(0, 6) == 0;
      s = $urandom_range(0, 3) == 0;
      cycle(r, a, g, s);
      hold = r && !bus.gnt;
    end
    for (int i = 0; i < 10; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0);
    chk("rand_drained", 32'(q.size()), 32'h0);
    chk("rand_busy", 32'(busy), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rv32imf_obi_instr_responder.md
RV32IMF_OBI_INSTR_RESPONDER -- requirements
Module: rv32imf_obi_instr_responder

Interface
REQ-001 Parameter MEM_BASE, 32'h0000_0000: byte address of the first memory word.
REQ-002 Parameter MEM_WORDS, 16384: number of 32-bit words backed by RAM; power of two.
REQ-003 Parameter DEPTH, 2: maximum granted-but-unanswered transactions; at least 1.
REQ-004 Derived constant RAM_AW = $clog2(MEM_WORDS).
REQ-005 clk  in  1  clock.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 instr_req_i  in  1  OBI request from fetch initiator.
REQ-008 instr_addr_i  in  32  OBI byte address; stable while req high and not granted.
REQ-009 instr_gnt_o  out  1  OBI grant, combinational.
REQ-010 instr_rvalid_o  out  1  OBI response valid.
REQ-011 instr_rdata_o  out  32  response data.
REQ-012 instr_err_o  out  1  response bus error, valid with rvalid.
REQ-013 gnt_stall_i  in  1  test backpressure; suppresses grant.
REQ-014 rsp_stall_i  in  1  test backpressure; holds responses in queue.
REQ-015 ram_req_o  out  1  synchronous RAM read enable.
REQ-016 ram_addr_o  out  RAM_AW  RAM word index.
REQ-017 ram_rdata_i  in  32  RAM data, valid one cycle after ram_req_o.
REQ-018 busy_o  out  1  high when any transaction is in flight or queued.

Function
REQ-019 occ = inflight_q + fifo_count; pop = instr_rvalid_o.
REQ-020 instr_gnt_o SHALL = instr_req_i & ~gnt_stall_i & ((occ - pop) < DEPTH).
REQ-021 in_range SHALL be true when MEM_BASE <= addr < MEM_BASE + 4*MEM_WORDS; the check is done in 33-bit arithmetic so the upper bound cannot wrap.
REQ-022 Address bits [1:0] SHALL be ignored; a non-zero value does not cause an error.
REQ-023 ram_req_o SHALL = instr_gnt_o & in_range.
REQ-024 ram_addr_o SHALL = (instr_addr_i - MEM_BASE) >> 2, truncated to RAM_AW bits.
REQ-025 On every grant, inflight_q SHALL be set to 1 for the next cycle, and err_q SHALL be set to ~in_range.
REQ-026 When inflight_q = 1, the pair {ram_rdata_i, 0} SHALL be pushed into the response FIFO that cycle; if err_q = 1, the pair {32'h0, 1} is pushed instead.
REQ-027 instr_rvalid_o SHALL = fifo not empty & ~rsp_stall_i.
- The head entry SHALL drive instr_rdata_o and instr_err_o; both are zero when the FIFO is empty.
REQ-028 Minimum latency: a grant in cycle N SHALL produce rvalid in cycle N+2.
- Back-to-back grants SHALL give one response per cycle.
REQ-029 Responses SHALL be returned in grant order.
- No response is ever dropped, duplicated, or returned without a prior grant.
REQ-030 A simultaneous push and pop SHALL leave fifo_count unchanged.
- The FIFO SHALL never overflow; this is guaranteed by REQ-020.
- Pop on empty cannot occur.
REQ-031 With occ = DEPTH and a pop in the same cycle, a grant SHALL be allowed in that cycle.
REQ-032 busy_o SHALL = (occ != 0).

Reset
REQ-033 Reset SHALL clear inflight_q, err_q, FIFO pointers and FIFO count.
- All outputs SHALL read 0 during reset and in the first cycle after reset.
REQ-034 Assertion of reset mid-transaction SHALL discard all queued and in-flight responses.
- No rvalid SHALL be produced for those transactions after reset is released.

Structure
REQ-035 The response struct type obi_rsp_t {rdata[31:0], err} SHALL be defined in rv32imf_pkg.
REQ-036 One sub-module SHALL be used: rv32imf_rsp_fifo, a synchronous FIFO of obi_rsp_t with parameter DEPTH, and outputs empty, full and count.
REQ-037 The RAM SHALL be external to this block.

Verification
REQ-038 Single fetch: addr 0x80 at MEM_BASE=0, RAM word 32 = 0xDEADBEEF -> gnt in cycle N, rvalid in N+2 with rdata 0xDEADBEEF and err 0.
REQ-039 Streaming: req held high for addresses 0x0, 0x4, 0x8, 0xC, no stalls -> four consecutive grants, then four consecutive in-order rvalids starting at N+2.
REQ-040 Backpressure at DEPTH=2: rsp_stall_i=1 for 5 cycles with req held high -> exactly 2 grants; after the stall drops, one grant per cycle resumes and the queued data returns in order.
REQ-041 Out-of-range: addr MEM_BASE+4*MEM_WORDS -> ram_req_o stays 0; rvalid at N+2 with err 1 and rdata 0.
REQ-042 Reset mid-operation: assert rst_n low with 2 responses queued -> after release, busy_o=0, no rvalid, and the first new grant returns correct data.
REQ-043 gnt_stall_i=1 with req high for 3 cycles -> gnt 0 throughout, address held stable; grant occurs in the cycle after the stall drops.
